bcd_uart_tx: RTL and testbench
==============================

// Module: bcd_uart_tx
// PURPOSE
//  Serial UART transmitter for a 2-digit BCD value (e.g. a date field "06", "19").
//  Sends the value as ASCII text "<bcd1><bcd0>\r\n" (8N1, LSB first) on tx_out.
//  Sends once after reset, then again whenever the input value changes.
//  Sits between a BCD counter/display source and the board's UART TX pin.
// PARAMETERS
//  BAUD_DIV  16  clk cycles per UART bit; 16 for simulation, 434 for 50 MHz/115200 builds
// PORTS
//  clk     in   1  single system clock, rising-edge active
//  rst     in   1  asynchronous, active-high reset
//  bcd1    in   4  tens digit (sent first)
//  bcd0    in   4  units digit
//  tx_out  out  1  UART serial output, idle high
// BEHAVIOUR
//  - Reset (async, active-high): tx_out=1, FSM=IDLE, baud counter=0, char index=0,
//    send_pending=1. The first frame starts after reset release.
//  - Frame: 4 characters sent back to back: 0x30+bcd1, 0x30+bcd0, 0x0D, 0x0A.
//    ASCII = 8-bit add of 0x30 and the 4-bit digit; no clamping (0xA -> 0x3A ':').
//  - Char format: start bit (0), 8 data bits LSB first, 1 stop bit (1).
//    Each bit is held for exactly BAUD_DIV clocks; 10*BAUD_DIV clocks per character.
//  - Snapshot: {bcd1,bcd0} latched into a sent-value register when a frame starts.
//    The whole frame uses the snapshot; input changes mid-frame do not alter it.
//  - Trigger: in IDLE, start a frame if send_pending=1 or inputs != sent-value.
//    Start bit drives tx_out low on the clock after the trigger is detected.
//    send_pending clears when the frame starts.
//  - FSM states:
//    IDLE -> START on trigger.
//    START -> DATA after BAUD_DIV clks.
//    DATA -> STOP after 8 bits.
//    STOP -> START for the next char (index<3), or -> IDLE after char 3.
//    In IDLE, tx_out=1 and the baud counter is held at 0.
//  - Baud counter: counts 0..BAUD_DIV-1 and wraps; the bit advances on the wrap.
//    The counter restarts at 0 when START is entered from IDLE.
//  - Back-to-back: if the inputs changed during a frame, a new frame starts from IDLE
//    (one idle clock minimum) with the new value.
//  - Reset mid-frame: tx_out returns to 1 immediately; the partial frame is abandoned.
//  - tx_out is driven from a register (glitch-free).
// TESTING
//  - rst=1 -> tx_out=1 throughout. Release with bcd1=0, bcd0=6 held -> decode
//    0x30,0x36,0x0D,0x0A, then tx_out stays 1.
//  - After the idle from the previous case, set bcd1=1, bcd0=9 -> one frame
//    0x31,0x39,0x0D,0x0A. Whole frame within 640 clks (BAUD_DIV=16).
//  - Measure bit widths: every start, data and stop bit is exactly 16 clks.
//    Stop-to-next-start spacing inside a frame is 0 extra clks.
//  - Change 06->19 during the 2nd char -> the current frame still sends "06\r\n",
//    then a second frame sends "19\r\n".
//  - Inputs constant for 5000 clks after a frame -> no further start bits.
//  - bcd1=0xA, bcd0=0xF -> frame bytes 0x3A,0x3F,0x0D,0x0A.
//  - Assert rst mid data bit -> tx_out=1 the same instant.
//    After release, a full frame of the current value is sent.

Source files
------------

// File: rtl/bcd_uart_tx.sv
// 8N1 UART transmitter sending a 2-digit BCD value as "<d1><d0>\r\n".
// Resends after reset and whenever the input value differs from the last frame.
module bcd_uart_tx #(
    parameter int BAUD_DIV = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] bcd1,
    input  logic [3:0] bcd0,
    output logic       tx_out
);

    localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_baud_cnt;
    logic [2:0]      r_bit_idx;
    logic [1:0]      r_char_idx;
    logic [7:0]      r_sent;
    logic            r_pending;
    logic            r_tx;

    logic [7:0]      w_in;
    logic            w_trig;
    logic            w_wrap;
    logic [2:0]      w_next_bit;
    logic [7:0]      w_char;

    assign w_in       = {bcd1, bcd0};
    assign w_trig     = r_pending || (w_in != r_sent);
    assign w_wrap     = (r_baud_cnt == CW'(BAUD_DIV - 1));
    assign w_next_bit = r_bit_idx + 3'd1;
    assign tx_out     = r_tx;

    // Characters are always built from the snapshot, never the live inputs
    always_comb begin
        w_char = 8'h0A;
        unique case (r_char_idx)
            2'd0: w_char = 8'h30 + {4'h0, r_sent[7:4]};
            2'd1: w_char = 8'h30 + {4'h0, r_sent[3:0]};
            2'd2: w_char = 8'h0D;
            2'd3: w_char = 8'h0A;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_baud_cnt <= '0;
            r_bit_idx  <= '0;
            r_char_idx <= '0;
            r_sent     <= '0;
            r_pending  <= 1'b1;
            r_tx       <= 1'b1;
        end else begin
            if (r_state == S_IDLE || w_wrap) begin
                r_baud_cnt <= '0;
            end else begin
                r_baud_cnt <= r_baud_cnt + CW'(1);
            end

            case (r_state)
                S_IDLE: begin
                    r_tx <= 1'b1;
                    if (w_trig) begin
                        r_state    <= S_START;
                        r_sent     <= w_in;
                        r_pending  <= 1'b0;
                        r_char_idx <= '0;
                        r_tx       <= 1'b0;
                    end
                end
                S_START: begin
                    if (w_wrap) begin
                        r_state   <= S_DATA;
                        r_bit_idx <= '0;
                        r_tx      <= w_char[0];
                    end
                end
                S_DATA: begin
                    if (w_wrap) begin
                        if (r_bit_idx == 3'd7) begin
                            r_state <= S_STOP;
                            r_tx    <= 1'b1;
                        end else begin
                            r_bit_idx <= w_next_bit;
                            r_tx      <= w_char[w_next_bit];
                        end
                    end
                end
                S_STOP: begin
                    if (w_wrap) begin
                        if (r_char_idx == 2'd3) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_state    <= S_START;
                            r_char_idx <= r_char_idx + 2'd1;
                            r_tx       <= 1'b0;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_uart_tx.sv
// Scoreboard bench for bcd_uart_tx: stimulus queues expected bytes,
// a line monitor decodes the serial stream and checks bit timing.
module tb_bcd_uart_tx;

    localparam int BD = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] bcd1 = 4'h0;
    logic [3:0] bcd0 = 4'h6;
    logic       tx;

    int vectors = 0;
    int miscompares = 0;
    logic [7:0] q[$];
    logic [7:0] sent;
    int mon_pos = 0;

    bcd_uart_tx #(.BAUD_DIV(BD)) dut (
        .clk   (clk),
        .rst   (rst),
        .bcd1  (bcd1),
        .bcd0  (bcd0),
        .tx_out(tx)
    );

    always #5 clk = ~clk;

    task automatic push_frame(input logic [7:0] v);
        q.push_back(8'h30 + {4'h0, v[7:4]});
        q.push_back(8'h30 + {4'h0, v[3:0]});
        q.push_back(8'h0D);
        q.push_back(8'h0A);
    endtask

    task automatic set_val(input logic [7:0] v);
        @(negedge clk);
        bcd1 = v[7:4];
        bcd0 = v[3:0];
        if (v != sent) begin
            push_frame(v);
            sent = v;
        end
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        int quiet = 0;
        while (n < budget && !(q.size() == 0 && quiet >= 20)) begin
            @(negedge clk);
            n++;
            quiet = (tx === 1'b1) ? quiet + 1 : 0;
        end
        vectors++;
        if (q.size() != 0 || quiet < 20) begin
            miscompares++;
            $display("FAIL idle_timeout pending=%0d quiet=%0d want pending=0", q.size(), quiet);
        end
    endtask

    // Called at the negedge where the start bit is first seen low
    task automatic decode_char(output bit start_seen);
        logic [7:0] b;
        logic [7:0] e;
        logic bitv;
        bit ok;
        b = '0;
        bitv = 1'b0;
        ok = 1'b1;
        start_seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            for (int j = 0; j < BD; j++) begin
                if (!(i == 0 && j == 0)) @(negedge clk);
                if (rst) return;
                if (j == 0) bitv = tx;
                else if (tx !== bitv) ok = 1'b0;
            end
            if (i >= 1 && i <= 8) b[i-1] = bitv;
            if (i == 0 && bitv !== 1'b0) ok = 1'b0;
            if (i == 9 && bitv !== 1'b1) ok = 1'b0;
        end
        vectors++;
        if (q.size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_char got=%h want=none", b);
        end else begin
            e = q.pop_front();
            if (!ok || b !== e) begin
                miscompares++;
                $display("FAIL char got=%h framing_ok=%0d want=%h", b, ok, e);
            end
        end
        @(negedge clk);
        if (rst) return;
        vectors++;
        if (mon_pos < 3) begin
            if (tx !== 1'b0) begin
                miscompares++;
                $display("FAIL char_gap got tx=%b want 0 (next start)", tx);
            end
            mon_pos++;
        end else begin
            if (tx !== 1'b1) begin
                miscompares++;
                $display("FAIL frame_end got tx=%b want 1 (idle)", tx);
            end
            mon_pos = 0;
        end
        start_seen = (tx === 1'b0);
    endtask

    initial begin : monitor
        bit have;
        have = 1'b0;
        forever begin
            if (!have) @(negedge clk);
            have = 1'b0;
            if (!rst && tx === 1'b0) decode_char(have);
        end
    end

    initial begin : stim
        int n;
        int falls;
        logic prev;
        logic [7:0] v1;
        logic [7:0] v2;

        sent = 8'h06;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            vectors++;
            if (tx !== 1'b1) begin
                miscompares++;
                $display("FAIL reset_tx got=%b want=1", tx);
            end
        end
        push_frame(8'h06);
        rst = 1'b0;
        wait_idle(1000);

        set_val(8'h19);
        n = 0;
        while (q.size() != 0 && n < 700) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (n < 640 || n > 641) begin
            miscompares++;
            $display("FAIL frame_len got=%0d want=640..641", n);
        end
        wait_idle(200);

        set_val(8'h06);
        repeat (200) @(negedge clk);
        set_val(8'h19);
        wait_idle(1500);

        set_val(8'hAF);
        wait_idle(1000);

        falls = 0;
        prev = tx;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (prev === 1'b1 && tx === 1'b0) falls++;
            prev = tx;
        end
        vectors++;
        if (falls != 0) begin
            miscompares++;
            $display("FAIL quiet_line got=%0d starts want=0", falls);
        end

        for (int k = 0; k < 12; k++) begin
            v1 = 8'($urandom_range(0, 255));
            set_val(v1);
            if ($urandom_range(0, 1) == 1) begin
                repeat ($urandom_range(2, 600)) @(negedge clk);
                v2 = 8'($urandom_range(0, 255));
                set_val(v2);
            end
            wait_idle(1500);
        end

        set_val(8'h42);
        repeat (BD + 3 * BD + 5) @(negedge clk);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        vectors++;
        if (tx !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_mid_frame got=%b want=1", tx);
        end
        q.delete();
        mon_pos = 0;
        repeat (3) @(negedge clk);
        vectors++;
        if (tx !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_hold got=%b want=1", tx);
        end
        push_frame({bcd1, bcd0});
        sent = {bcd1, bcd0};
        rst = 1'b0;
        wait_idle(1000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
